// File: rtl/cpu_seq_pkg.sv
// Shared types and field constants for the CPU control sequencer.
package cpu_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_FETCH2 = 4'd3,
    S_MEMRD  = 4'd4,
    S_OPLOAD = 4'd5,
    S_EXEC   = 4'd6,
    S_WB     = 4'd7,
    S_HALT   = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  localparam logic [1:0] OT_MOVE    = 2'b00;
  localparam logic [1:0] OT_ARITH   = 2'b01;
  localparam logic [1:0] OT_LOGIC   = 2'b10;
  localparam logic [1:0] OT_ILLEGAL = 2'b11;

  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam logic [3:0] OPC_CMP  = 4'hE;

  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_IMM = 2'b01;
  localparam logic [1:0] MODE_DIR = 2'b10;

  localparam logic [1:0] BYTE_1 = 2'b01;
  localparam logic [1:0] BYTE_2 = 2'b10;

endpackage

// File: rtl/cpu_seq_wait_timer.sv
// MEMRD wait counter; expired flags the last allowed wait cycle.
module cpu_seq_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (en) cnt_q <= cnt_q + 4'd1;
  end

  // This cycle's increment would reach WAIT_MAX.
  assign expired = en && (cnt_q == 4'(WAIT_MAX - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/operand/execute/writeback control FSM
// for the 16-bit CPU datapath.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int RET_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       ins_byte,
  input  logic [1:0]       ins_mode,
  input  logic [1:0]       ins_ot,
  input  logic [3:0]       ins_opcode,
  input  logic             mem_ready,
  output logic             ins_load,
  output logic             op1_load,
  output logic             op2_load,
  output logic             reg_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ram_rd,
  output logic             halted,
  output logic             trap,
  output logic [3:0]       state,
  output logic [RET_W-1:0] retired
);

  state_t           state_q, state_d;
  logic             no_wb_q;
  logic [RET_W-1:0] ret_q;
  logic             wt_clr, wt_en, wt_exp;

  cpu_seq_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clr    (wt_clr),
    .en     (wt_en),
    .expired(wt_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      no_wb_q <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        no_wb_q <= (ins_ot == OT_MOVE) &&
                   (ins_opcode == OPC_CMP);
      if (state_q == S_WB)
        ret_q <= ret_q + RET_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    ins_load = 1'b0;
    op1_load = 1'b0;
    op2_load = 1'b0;
    reg_load = 1'b0;
    pc_inc   = 1'b0;
    ram_rd   = 1'b0;
    wt_clr   = 1'b1;
    wt_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_FETCH;
      end
      S_FETCH: begin
        ins_load = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (ins_ot == OT_ILLEGAL)
          state_d = S_TRAP;
        else if (ins_ot == OT_MOVE &&
                 ins_opcode == OPC_HALT)
          state_d = S_HALT;
        else if (ins_byte == BYTE_2)
          state_d = S_FETCH2;
        else if (ins_mode == MODE_DIR)
          state_d = S_MEMRD;
        else
          state_d = S_OPLOAD;
      end
      S_FETCH2: begin
        pc_inc  = 1'b1;
        state_d = (ins_mode == MODE_DIR) ?
                  S_MEMRD : S_OPLOAD;
      end
      S_MEMRD: begin
        ram_rd = 1'b1;
        wt_clr = mem_ready;
        wt_en  = !mem_ready;
        if (mem_ready) state_d = S_OPLOAD;
        else if (wt_exp) state_d = S_TRAP;
      end
      S_OPLOAD: begin
        op1_load = 1'b1;
        op2_load = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_WB: begin
        reg_load = !no_wb_q;
        pc_inc   = 1'b1;
        state_d  = en ? S_FETCH : S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      S_TRAP: state_d = S_TRAP;
      // Unused encodings fall into TRAP.
      default: state_d = S_TRAP;
    endcase
  end

  assign pc_load = 1'b0;
  assign halted  = (state_q == S_HALT);
  assign trap    = (state_q == S_TRAP);
  assign state   = state_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: per-instruction expected cycle sequences
// built from the sequencing rules, compared every cycle.
module tb_cpu_sequencer;

  // Narrow retired counter keeps the wrap test short.
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    ins_byte = 2'b01;
  logic [1:0]    ins_mode = 2'b00;
  logic [1:0]    ins_ot = 2'b01;
  logic [3:0]    ins_opcode = 4'h0;
  logic          mem_ready = 1'b0;
  logic          ins_load, op1_load, op2_load, reg_load;
  logic          pc_inc, pc_load, ram_rd, halted, trap;
  logic [3:0]    state;
  logic [RW-1:0] retired;

  cpu_sequencer #(
    .WAIT_MAX(15),
    .RET_W   (RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ins_byte  (ins_byte),
    .ins_mode  (ins_mode),
    .ins_ot    (ins_ot),
    .ins_opcode(ins_opcode),
    .mem_ready (mem_ready),
    .ins_load  (ins_load),
    .op1_load  (op1_load),
    .op2_load  (op2_load),
    .reg_load  (reg_load),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .ram_rd    (ram_rd),
    .halted    (halted),
    .trap      (trap),
    .state     (state),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic          il, opl, rl, pci, rrd;
    logic [RW-1:0] ret;
    logic          en, rdy;
    logic [1:0]    by, md, ot;
    logic [3:0]    opc;
  } rec_t;

  rec_t q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int cnt_pci, cnt_rrd, cnt_rl, cnt_mem;
  int t_fetch, lat;

  logic [RW-1:0] m_ret;
  logic          m_en;
  logic          m_idle;
  logic [1:0]    g_by, g_md, g_ot;
  logic [3:0]    g_opc;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] st,
                      input logic il, input logic opl,
                      input logic rl, input logic pci,
                      input logic rrd, input logic rdy);
    rec_t r;
    r.st = st; r.il = il; r.opl = opl; r.rl = rl;
    r.pci = pci; r.rrd = rrd; r.ret = m_ret;
    r.en = m_en; r.rdy = rdy;
    r.by = g_by; r.md = g_md; r.ot = g_ot; r.opc = g_opc;
    q.push_back(r);
  endtask

  // Append the expected cycles of one instruction.
  // lat: MEMRD cycle on which ready arrives (0 = never).
  // drop: en falls in EXEC, parking in IDLE after WB.
  task automatic gen(input logic [1:0] by,
                     input logic [1:0] md,
                     input logic [1:0] ot,
                     input logic [3:0] opc,
                     input int lat, input bit drop);
    g_by = by; g_md = md; g_ot = ot; g_opc = opc;
    if (m_idle) begin
      m_en = 1'b1;
      push(4'd0, 0, 0, 0, 0, 0, 0);
      m_idle = 1'b0;
    end
    push(4'd1, 1, 0, 0, 0, 0, 0);
    push(4'd2, 0, 0, 0, 0, 0, 0);
    if (ot == 2'b11) begin
      repeat (5) push(4'd9, 0, 0, 0, 0, 0, 0);
      return;
    end
    if (ot == 2'b00 && opc == 4'hF) begin
      repeat (20) push(4'd8, 0, 0, 0, 0, 0, 0);
      return;
    end
    if (by == 2'b10) push(4'd3, 0, 0, 0, 1, 0, 0);
    if (md == 2'b10) begin
      for (int k = 1; ; k++) begin
        push(4'd4, 0, 0, 0, 0, 1, k == lat);
        if (k == lat) break;
        if (k == 15) begin
          repeat (5) push(4'd9, 0, 0, 0, 0, 0, 0);
          return;
        end
      end
    end
    push(4'd5, 0, 1, 0, 0, 0, 0);
    if (drop) m_en = 1'b0;
    push(4'd6, 0, 0, 0, 0, 0, 0);
    push(4'd7, 0, 0, !(ot == 2'b00 && opc == 4'hE), 1, 0, 0);
    m_ret = m_ret + 1'b1;
    if (!m_en) m_idle = 1'b1;
  endtask

  // Drive each queued cycle and compare the DUT against it.
  task automatic run_q(input int n);
    rec_t r;
    logic [8:0] act, exp;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      en = r.en; mem_ready = r.rdy;
      ins_byte = r.by; ins_mode = r.md;
      ins_ot = r.ot; ins_opcode = r.opc;
      @(negedge clk);
      cyc++;
      act = {ins_load, op1_load, op2_load, reg_load,
             pc_inc, pc_load, ram_rd, halted, trap};
      exp = {r.il, r.opl, r.opl, r.rl, r.pci, 1'b0,
             r.rrd, r.st == 4'd8, r.st == 4'd9};
      chk("state", cyc, 32'(state), 32'(r.st));
      chk("strobes", cyc, 32'(act), 32'(exp));
      chk("retired", cyc, 32'(retired), 32'(r.ret));
      if (pc_inc) cnt_pci++;
      if (ram_rd) cnt_rrd++;
      if (reg_load) cnt_rl++;
      if (state == 4'd4) cnt_mem++;
      if (state == 4'd1) t_fetch = cyc;
      if (state == 4'd7) lat = cyc - t_fetch + 1;
    end
  endtask

  task automatic clr();
    cnt_pci = 0; cnt_rrd = 0; cnt_rl = 0;
    cnt_mem = 0; lat = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", cyc, 32'(state), 32'd0);
    chk("rst_outs", cyc,
        32'({ins_load, op1_load, op2_load, reg_load,
             pc_inc, pc_load, ram_rd, halted, trap}), 32'd0);
    chk("rst_ret", cyc, 32'(retired), 32'd0);
    q.delete();
    m_ret = '0; m_en = 1'b0; m_idle = 1'b1;
  endtask

  initial begin
    g_by = 2'b01; g_md = 2'b00; g_ot = 2'b01; g_opc = 4'h0;
    do_reset();

    // Register-mode ADD.
    clr();
    gen(2'b01, 2'b00, 2'b01, 4'h0, 0, 0);
    run_q(1000);
    chk("add_lat", cyc, 32'(lat), 32'd5);
    chk("add_rl", cyc, 32'(cnt_rl), 32'd1);
    chk("add_pci", cyc, 32'(cnt_pci), 32'd1);
    step();
    chk("add_ret", cyc, 32'(retired), 32'd1);
    do_reset();

    // 2-word direct, ready on 3rd MEMRD cycle.
    clr();
    gen(2'b10, 2'b10, 2'b01, 4'h3, 3, 0);
    run_q(1000);
    chk("dir2_lat", cyc, 32'(lat), 32'd9);
    chk("dir2_pci", cyc, 32'(cnt_pci), 32'd2);
    chk("dir2_rrd", cyc, 32'(cnt_rrd), 32'd3);

    // 2-word immediate, back to back.
    clr();
    gen(2'b10, 2'b01, 2'b10, 4'h5, 0, 0);
    run_q(1000);
    chk("imm2_lat", cyc, 32'(lat), 32'd6);
    chk("imm2_pci", cyc, 32'(cnt_pci), 32'd2);

    // 1-word direct, ready on first MEMRD cycle.
    clr();
    gen(2'b01, 2'b10, 2'b01, 4'h0, 1, 0);
    run_q(1000);
    chk("dir1_rrd", cyc, 32'(cnt_rrd), 32'd1);
    chk("dir1_lat", cyc, 32'(lat), 32'd6);

    // en dropped in EXEC, then re-raised.
    gen(2'b01, 2'b00, 2'b01, 4'h1, 0, 1);
    run_q(1000);
    step();
    chk("drop_idle", cyc, 32'(state), 32'd0);
    gen(2'b01, 2'b00, 2'b10, 4'h2, 0, 0);
    run_q(1000);
    do_reset();

    // CMP then HALT.
    clr();
    gen(2'b01, 2'b00, 2'b00, 4'hE, 0, 0);
    gen(2'b01, 2'b00, 2'b00, 4'hF, 0, 0);
    run_q(1000);
    chk("cmp_rl", cyc, 32'(cnt_rl), 32'd0);
    chk("cmp_pci", cyc, 32'(cnt_pci), 32'd1);
    chk("halt_state", cyc, 32'(state), 32'd8);
    chk("halt_flag", cyc, 32'(halted), 32'd1);
    chk("halt_ret", cyc, 32'(retired), 32'd1);
    do_reset();

    // Illegal op type.
    gen(2'b01, 2'b00, 2'b11, 4'h0, 0, 0);
    run_q(1000);
    chk("ill_state", cyc, 32'(state), 32'd9);
    chk("ill_trap", cyc, 32'(trap), 32'd1);
    do_reset();

    // mem_ready stuck low.
    clr();
    gen(2'b10, 2'b10, 2'b01, 4'h0, 0, 0);
    run_q(1000);
    chk("stuck_mem", cyc, 32'(cnt_mem), 32'd15);
    chk("stuck_trap", cyc, 32'(trap), 32'd1);
    do_reset();

    // Reset mid-MEMRD, then a 14-cycle wait must not trap.
    gen(2'b10, 2'b10, 2'b01, 4'h0, 0, 0);
    run_q(6);
    do_reset();
    clr();
    gen(2'b01, 2'b10, 2'b01, 4'h0, 14, 0);
    run_q(1000);
    chk("wait14_mem", cyc, 32'(cnt_mem), 32'd14);
    do_reset();

    // Retired counter wrap.
    for (int i = 0; i < (1 << RW) - 2; i++)
      gen(2'b01, 2'b00, 2'b01, 4'h0, 0, 0);
    gen(2'b01, 2'b00, 2'b01, 4'h0, 0, 1);
    run_q(100000);
    step();
    chk("ret_full", cyc, 32'(retired), 32'((1 << RW) - 1));
    gen(2'b01, 2'b00, 2'b01, 4'h0, 0, 1);
    run_q(1000);
    step();
    chk("ret_wrap", cyc, 32'(retired), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
